rf_mp_sb: RTL and testbench
===========================

// Module: rf_mp_sb
// PURPOSE
//  Multi-read-port register file with write-to-read bypass, per-register busy scoreboard and a
//  sequenced bulk-clear engine. Sits in the decode stage of the pipelined core: N_RD operand
//  reads per cycle, one write-back port, busy bits tracking in-flight producers for hazard
//  stalls, and a DEPTH-cycle clear used on context switch without asserting reset.
// PARAMETERS
//  WIDTH    32  data width of each register
//  DEPTH    32  number of registers; AW = $clog2(DEPTH)
//  N_RD     2   number of read ports (>=1)
//  ZERO_REG 1   1: register 0 reads 0, ignores writes, is never busy
//  BYPASS   1   1: a same-cycle write to a read address is forwarded to the read port
// PORTS
//  clk_i        in   1           clock, all state updates on rising edge
//  rstn_i       in   1           asynchronous active-low reset
//  chip_en_i    in   1           block enable; 0 => no state update, rs_o all 0
//  we_i         in   1           write enable, active-low
//  rd_addr_i    in   AW          write address
//  data_i       in   WIDTH       write data
//  rs_addr_i    in   N_RD*AW     read addresses, port k at [k*AW +: AW]
//  rs_o         out  N_RD*WIDTH  read data, port k at [k*WIDTH +: WIDTH]
//  busy_set_i   in   1           mark busy_addr_i as having an in-flight producer
//  busy_addr_i  in   AW          scoreboard set address
//  rs_busy_o    out  N_RD        busy flag for each read address
//  clr_i        in   1           start bulk clear (pulse)
//  ready_o      out  1           1 = IDLE, writes/sets/reads valid; 0 = clearing
// BEHAVIOUR
//  Reset (async): all regs 0, all busy 0, FSM IDLE, clear counter 0 => ready_o=1, rs_o=0, rs_busy_o=0.
//  wr_act = chip_en_i & ~we_i & ready_o & ~(ZERO_REG & rd_addr_i==0).
//  Write: wr_act at edge => regs[rd_addr_i]<=data_i, busy[rd_addr_i]<=0. One-cycle write latency.
//  Set:   chip_en_i & busy_set_i & ready_o & ~(ZERO_REG & busy_addr_i==0) => busy[busy_addr_i]<=1.
//  Set and write to same address at same edge: set wins (busy=1, data still written).
//  Read port k (combinational, zero latency), priority order:
//   1. chip_en_i==0 or ready_o==0 -> rs_o=0
//   2. ZERO_REG & addr==0         -> 0
//   3. BYPASS & wr_act & rd_addr_i==addr -> data_i
//   4. otherwise                  -> regs[addr]
//  rs_busy_o[k]: 1 while ready_o==0; 0 if ZERO_REG & addr==0; 0 if BYPASS & wr_act &
//   rd_addr_i==addr & ~(set to same addr this cycle); else busy[addr]. Not gated by chip_en_i.
//  Ports reading the same address return identical values; no read-port conflicts exist.
//  FSM: IDLE --(chip_en_i & clr_i)--> CLEAR with cnt<=0.
//   CLEAR: each edge regs[cnt]<=0, busy[cnt]<=0, cnt<=cnt+1; at cnt==DEPTH-1 -> IDLE, cnt<=0.
//   ready_o = (state==IDLE), decoded from state register (no combinational path from clr_i).
//   ready_o is low for exactly DEPTH cycles after the clr_i sampling edge.
//  In CLEAR: we_i, busy_set_i and clr_i are ignored (not queued).
//  clr_i with a write at the same IDLE edge: the write lands, then the clear wipes it.
//  Reset mid-clear: immediate return to IDLE, all state 0; clear is not resumed.
//  DEPTH not a power of two: addresses >= DEPTH are ignored on write/set and read as 0, not busy.
// TESTING
//  T1 reset; write x5=0xDEAD_BEEF (we_i=0); next cycle rs_addr={5,5} -> both ports 0xDEAD_BEEF.
//  T2 write x0=0x1234 and busy_set x0; read x0 -> rs_o=0, rs_busy_o=0 (ZERO_REG=1).
//  T3 busy_set x7; next cycle rs_busy_o=1 on port reading x7; write x7=0xA5 same cycle as
//     read x7 -> rs_o=0xA5, rs_busy_o=0 (bypass); following cycle busy[7]=0 registered.
//  T4 same edge: busy_set x3 + write x3=0x11 -> after edge read x3 = 0x11, rs_busy_o=1.
//  T5 fill x1..x31, pulse clr_i -> ready_o=0 for 32 cycles, rs_o=0, rs_busy_o all 1; writes
//     during CLEAR are dropped; after ready_o=1 all registers read 0 and are not busy.
//  T6 pulse clr_i, assert rstn_i=0 at cycle 10 of CLEAR -> ready_o=1 immediately, regs all 0;
//     chip_en_i=0 at any time -> rs_o=0, state unchanged.

Source files
------------

// File: rtl/rf_mp_sb_if.sv
// Decode-stage register file bus: write-back port, N_RD operand read ports,
// busy scoreboard set port and bulk-clear control.
interface rf_mp_sb_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  parameter int N_RD  = 2
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic                    chip_en_i;
  logic                    we_i;
  logic [AW-1:0]           rd_addr_i;
  logic [WIDTH-1:0]        data_i;
  logic [N_RD*AW-1:0]      rs_addr_i;
  logic [N_RD*WIDTH-1:0]   rs_o;
  logic                    busy_set_i;
  logic [AW-1:0]           busy_addr_i;
  logic [N_RD-1:0]         rs_busy_o;
  logic                    clr_i;
  logic                    ready_o;

  modport master (
    output chip_en_i, we_i, rd_addr_i, data_i, rs_addr_i,
           busy_set_i, busy_addr_i, clr_i,
    input  rs_o, rs_busy_o, ready_o
  );

  modport slave (
    input  chip_en_i, we_i, rd_addr_i, data_i, rs_addr_i,
           busy_set_i, busy_addr_i, clr_i,
    output rs_o, rs_busy_o, ready_o
  );
endinterface

// File: rtl/rf_mp_sb.sv
// Multi-read-port register file with write-to-read bypass, per-register busy
// scoreboard and a DEPTH-cycle sequenced bulk-clear engine.
module rf_mp_sb #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int N_RD     = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic      clk_i,
  input  logic      rstn_i,
  rf_mp_sb_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic            ready;
  logic            wr_act, set_act, clr_start, clr_step;
  logic [WIDTH-1:0] regs_rd [DEPTH];
  logic [DEPTH-1:0] busy_vec;

  function automatic logic in_range(input logic [AW-1:0] a);
    return ({1'b0, a} < DEPTH_W);
  endfunction

  // Addresses that can hold state: in range and not the hardwired zero register.
  function automatic logic addr_live(input logic [AW-1:0] a);
    return in_range(a) && !(ZERO_REG && (a == '0));
  endfunction

  assign wr_act    = bus.chip_en_i & ~bus.we_i & ready & addr_live(bus.rd_addr_i);
  assign set_act   = bus.chip_en_i & bus.busy_set_i & ready & addr_live(bus.busy_addr_i);
  assign clr_start = bus.chip_en_i & bus.clr_i & ready;
  assign clr_step  = bus.chip_en_i & (state_q == ST_CLEAR);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A disabled block holds the clear sequence where it is.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_start) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        if (bus.chip_en_i) begin
          if (cnt_q == LAST) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    ready = (state_q == ST_IDLE);
  end

  assign bus.ready_o = ready;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_reg
      localparam logic [AW-1:0] IDX = AW'(gi);
      logic [WIDTH-1:0] reg_q;
      logic             busy_q;

      // A scoreboard set beats the write-back clear when both hit this entry.
      always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
          reg_q  <= '0;
          busy_q <= 1'b0;
        end else if (clr_step && (cnt_q == IDX)) begin
          reg_q  <= '0;
          busy_q <= 1'b0;
        end else begin
          if (wr_act && (bus.rd_addr_i == IDX)) begin
            reg_q <= bus.data_i;
          end
          if (set_act && (bus.busy_addr_i == IDX)) begin
            busy_q <= 1'b1;
          end else if (wr_act && (bus.rd_addr_i == IDX)) begin
            busy_q <= 1'b0;
          end
        end
      end

      assign regs_rd[gi]  = reg_q;
      assign busy_vec[gi] = busy_q;
    end

    for (gi = 0; gi < N_RD; gi++) begin : g_rd
      logic [AW-1:0]    a;
      logic             fwd;
      logic [WIDTH-1:0] rd_data;
      logic             rd_busy;

      assign a   = bus.rs_addr_i[gi*AW +: AW];
      assign fwd = BYPASS && wr_act && (bus.rd_addr_i == a);

      always_comb begin
        rd_data = '0;
        rd_busy = 1'b0;
        if (!ready) begin
          rd_busy = 1'b1;
        end else if (!addr_live(a)) begin
          rd_busy = 1'b0;
        end else if (fwd && !(set_act && (bus.busy_addr_i == a))) begin
          rd_busy = 1'b0;
        end else begin
          rd_busy = busy_vec[a];
        end
        if (bus.chip_en_i && ready && addr_live(a)) begin
          rd_data = fwd ? bus.data_i : regs_rd[a];
        end
      end

      assign bus.rs_o[gi*WIDTH +: WIDTH] = rd_data;
      assign bus.rs_busy_o[gi]           = rd_busy;
    end
  endgenerate
endmodule

// File: tb/tb_rf_mp_sb.sv
// Bench for rf_mp_sb: hand-derived vector table, clear/reset sequences and
// randomized traffic against a behavioural register-file model.
module tb_rf_mp_sb;
  localparam int WIDTH = 32;
  localparam int DEPTH = 32;
  localparam int N_RD  = 2;
  localparam int AW    = 5;

  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  rf_mp_sb_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .N_RD(N_RD)) bus ();

  rf_mp_sb #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .N_RD(N_RD), .ZERO_REG(1'b1), .BYPASS(1'b1)
  ) dut (
    .clk_i (clk),
    .rstn_i(rstn),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: register contents, busy flags and remaining clear work.
  logic [WIDTH-1:0] m_regs [DEPTH];
  logic             m_busy [DEPTH];
  int               clr_left;
  int               clr_pos;

  typedef struct {
    logic             ce;
    logic             we;
    logic [AW-1:0]    rda;
    logic [WIDTH-1:0] d;
    logic [AW-1:0]    a0;
    logic [AW-1:0]    a1;
    logic             bs;
    logic [AW-1:0]    ba;
    logic             clr;
    logic [WIDTH-1:0] e0;
    logic [WIDTH-1:0] e1;
    logic [1:0]       eb;
    logic             erdy;
  } vec_t;

  vec_t tab [17];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    clr_left = 0;
    clr_pos  = 0;
  endtask

  // One clock of traffic: drive after the edge, compare with the model at the
  // falling edge, then advance the model to what the next edge commits.
  task automatic step(input logic ce, input logic we, input logic [AW-1:0] rda,
                      input logic [WIDTH-1:0] d, input logic [AW-1:0] a0,
                      input logic [AW-1:0] a1, input logic bs, input logic [AW-1:0] ba,
                      input logic clr, input string tag,
                      output logic [WIDTH-1:0] r0, output logic [WIDTH-1:0] r1,
                      output logic [1:0] bz, output logic rdy);
    logic             m_rdy, wr, set;
    logic [WIDTH-1:0] e [2];
    logic             eb [2];
    logic [AW-1:0]    ad [2];
    @(posedge clk);
    #1;
    bus.chip_en_i   = ce;
    bus.we_i        = we;
    bus.rd_addr_i   = rda;
    bus.data_i      = d;
    bus.rs_addr_i   = {a1, a0};
    bus.busy_set_i  = bs;
    bus.busy_addr_i = ba;
    bus.clr_i       = clr;
    m_rdy = (clr_left == 0);
    wr    = ce && !we && m_rdy && (rda != 0);
    set   = ce && bs && m_rdy && (ba != 0);
    ad[0] = a0;
    ad[1] = a1;
    for (int k = 0; k < 2; k++) begin
      if (!ce || !m_rdy || ad[k] == 0) e[k] = '0;
      else if (wr && rda == ad[k])     e[k] = d;
      else                             e[k] = m_regs[ad[k]];
      if (!m_rdy)                                      eb[k] = 1'b1;
      else if (ad[k] == 0)                             eb[k] = 1'b0;
      else if (wr && rda == ad[k] && !(set && ba == ad[k])) eb[k] = 1'b0;
      else                                             eb[k] = m_busy[ad[k]];
    end
    @(negedge clk);
    r0  = bus.rs_o[31:0];
    r1  = bus.rs_o[63:32];
    bz  = bus.rs_busy_o;
    rdy = bus.ready_o;
    $display("[%0t] %s ce=%0b we=%0b wa=%0d wd=%h bs=%0b ba=%0d clr=%0b ra=%0d/%0d rs=%h/%h busy=%b rdy=%0b",
             $time, tag, ce, we, rda, d, bs, ba, clr, a0, a1, r0, r1, bz, rdy);
    chk({tag, " rs0"}, 64'(r0), 64'(e[0]));
    chk({tag, " rs1"}, 64'(r1), 64'(e[1]));
    chk({tag, " busy"}, 64'(bz), 64'({eb[1], eb[0]}));
    chk({tag, " ready"}, 64'(rdy), 64'(m_rdy));
    if (ce) begin
      if (m_rdy) begin
        if (wr) begin
          m_regs[rda] = d;
          m_busy[rda] = 1'b0;
        end
        if (set) m_busy[ba] = 1'b1;
        if (clr) begin
          clr_left = DEPTH;
          clr_pos  = 0;
        end
      end else begin
        m_regs[clr_pos] = '0;
        m_busy[clr_pos] = 1'b0;
        clr_pos++;
        clr_left--;
      end
    end
  endtask

  initial begin
    logic [WIDTH-1:0] r0, r1;
    logic [1:0]       bz;
    logic             rdy;
    int               low_cnt;

    tab[0]  = '{1'b1, 1'b1, 5'd0, 32'h0,         5'd5, 5'd5, 1'b0, 5'd0, 1'b0, 32'h0,         32'h0,         2'b00, 1'b1};
    tab[1]  = '{1'b1, 1'b0, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd5, 1'b0, 5'd0, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b00, 1'b1};
    tab[2]  = '{1'b1, 1'b1, 5'd0, 32'h0,         5'd5, 5'd5, 1'b0, 5'd0, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b00, 1'b1};
    tab[3]  = '{1'b1, 1'b0, 5'd0, 32'h1234,      5'd0, 5'd5, 1'b1, 5'd0, 1'b0, 32'h0,         32'hDEAD_BEEF, 2'b00, 1'b1};
    tab[4]  = '{1'b1, 1'b1, 5'd0, 32'h0,         5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0,         32'h0,         2'b00, 1'b1};
    tab[5]  = '{1'b1, 1'b1, 5'd0, 32'h0,         5'd7, 5'd5, 1'b1, 5'd7, 1'b0, 32'h0,         32'hDEAD_BEEF, 2'b00, 1'b1};
    tab[6]  = '{1'b1, 1'b1, 5'd0, 32'h0,         5'd7, 5'd5, 1'b0, 5'd0, 1'b0, 32'h0,         32'hDEAD_BEEF, 2'b01, 1'b1};
    tab[7]  = '{1'b1, 1'b0, 5'd7, 32'hA5,        5'd7, 5'd7, 1'b0, 5'd0, 1'b0, 32'hA5,        32'hA5,        2'b00, 1'b1};
    tab[8]  = '{1'b1, 1'b1, 5'd0, 32'h0,         5'd7, 5'd7, 1'b0, 5'd0, 1'b0, 32'hA5,        32'hA5,        2'b00, 1'b1};
    tab[9]  = '{1'b1, 1'b0, 5'd3, 32'h11,        5'd3, 5'd3, 1'b1, 5'd3, 1'b0, 32'h11,        32'h11,        2'b00, 1'b1};
    tab[10] = '{1'b1, 1'b1, 5'd0, 32'h0,         5'd3, 5'd7, 1'b0, 5'd0, 1'b0, 32'h11,        32'hA5,        2'b01, 1'b1};
    tab[11] = '{1'b0, 1'b0, 5'd3, 32'hFF,        5'd3, 5'd7, 1'b0, 5'd0, 1'b0, 32'h0,         32'h0,         2'b01, 1'b1};
    tab[12] = '{1'b1, 1'b1, 5'd0, 32'h0,         5'd3, 5'd7, 1'b0, 5'd0, 1'b0, 32'h11,        32'hA5,        2'b01, 1'b1};
    tab[13] = '{1'b1, 1'b0, 5'd9, 32'h55,        5'd9, 5'd0, 1'b1, 5'd9, 1'b0, 32'h55,        32'h0,         2'b00, 1'b1};
    tab[14] = '{1'b1, 1'b1, 5'd0, 32'h0,         5'd9, 5'd0, 1'b0, 5'd0, 1'b0, 32'h55,        32'h0,         2'b01, 1'b1};
    tab[15] = '{1'b0, 1'b1, 5'd0, 32'h0,         5'd9, 5'd9, 1'b0, 5'd0, 1'b1, 32'h0,         32'h0,         2'b11, 1'b1};
    tab[16] = '{1'b1, 1'b1, 5'd0, 32'h0,         5'd9, 5'd9, 1'b0, 5'd0, 1'b0, 32'h55,        32'h55,        2'b11, 1'b1};

    bus.chip_en_i   = 1'b1;
    bus.we_i        = 1'b1;
    bus.rd_addr_i   = '0;
    bus.data_i      = '0;
    bus.rs_addr_i   = {5'd5, 5'd5};
    bus.busy_set_i  = 1'b0;
    bus.busy_addr_i = '0;
    bus.clr_i       = 1'b0;
    m_reset();

    #1 rstn = 1'b0;
    #2;
    chk("reset ready", 64'(bus.ready_o), 64'd1);
    chk("reset rs", 64'(bus.rs_o), 64'd0);
    chk("reset busy", 64'(bus.rs_busy_o), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;

    // Hand-derived vectors: write/bypass, zero register, scoreboard, chip enable.
    for (int i = 0; i < 17; i++) begin
      step(tab[i].ce, tab[i].we, tab[i].rda, tab[i].d, tab[i].a0, tab[i].a1,
           tab[i].bs, tab[i].ba, tab[i].clr, $sformatf("vec%0d", i), r0, r1, bz, rdy);
      chk($sformatf("tab%0d rs0", i), 64'(r0), 64'(tab[i].e0));
      chk($sformatf("tab%0d rs1", i), 64'(r1), 64'(tab[i].e1));
      chk($sformatf("tab%0d busy", i), 64'(bz), 64'(tab[i].eb));
      chk($sformatf("tab%0d ready", i), 64'(rdy), 64'(tab[i].erdy));
    end

    // Fill, then clear with a same-edge write; writes issued while clearing are lost.
    for (int i = 1; i < DEPTH; i++)
      step(1'b1, 1'b0, AW'(i), 32'h1000_0000 + i, AW'(i), AW'(i - 1), 1'b1, AW'(i),
           1'b0, "fill", r0, r1, bz, rdy);
    step(1'b1, 1'b0, 5'd4, 32'hBEEF, 5'd4, 5'd31, 1'b0, 5'd0, 1'b1, "clr_go", r0, r1, bz, rdy);
    low_cnt = 0;
    for (int i = 0; i < DEPTH + 8; i++) begin
      logic w;
      w = (clr_left > 0) ? 1'b0 : 1'b1;
      step(1'b1, w, AW'($urandom_range(1, 31)), $urandom, AW'($urandom), AW'($urandom),
           w ? 1'b0 : 1'b1, AW'($urandom_range(1, 31)), 1'b1 & ~w, "clearing", r0, r1, bz, rdy);
      if (rdy) break;
      low_cnt++;
    end
    chk("clear low cycles", 64'(low_cnt), 64'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 1'b1, 5'd0, 32'h0, AW'(i), AW'(DEPTH - 1 - i), 1'b0, 5'd0, 1'b0,
           "post_clr", r0, r1, bz, rdy);
      chk("post clear data", {r1, r0}, 64'd0);
      chk("post clear busy", 64'(bz), 64'd0);
    end

    // Partial clear with a chip-enable stall, then reset mid-clear.
    step(1'b1, 1'b0, 5'd20, 32'hCAFE_0020, 5'd20, 5'd31, 1'b1, 5'd31, 1'b0, "pre6", r0, r1, bz, rdy);
    step(1'b1, 1'b0, 5'd31, 32'hCAFE_0031, 5'd20, 5'd31, 1'b0, 5'd0, 1'b0, "pre6", r0, r1, bz, rdy);
    step(1'b1, 1'b1, 5'd0, 32'h0, 5'd20, 5'd31, 1'b0, 5'd0, 1'b1, "clr_go6", r0, r1, bz, rdy);
    for (int i = 0; i < 10; i++)
      step(1'b1, 1'b1, 5'd0, 32'h0, 5'd20, 5'd31, 1'b0, 5'd0, 1'b0, "clearing6", r0, r1, bz, rdy);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 5'd0, 32'h0, 5'd20, 5'd31, 1'b0, 5'd0, 1'b0, "stall6", r0, r1, bz, rdy);
      chk("stall keeps clearing", 64'(rdy), 64'd0);
    end
    @(posedge clk);
    #2;
    bus.chip_en_i = 1'b1;
    rstn = 1'b0;
    #1;
    chk("midclr reset ready", 64'(bus.ready_o), 64'd1);
    chk("midclr reset data", 64'(bus.rs_o), 64'd0);
    chk("midclr reset busy", 64'(bus.rs_busy_o), 64'd0);
    m_reset();
    @(negedge clk);
    rstn = 1'b1;
    step(1'b1, 1'b1, 5'd0, 32'h0, 5'd20, 5'd31, 1'b0, 5'd0, 1'b0, "after_rst", r0, r1, bz, rdy);
    chk("after reset data", {r1, r0}, 64'd0);
    chk("after reset ready", 64'(rdy), 64'd1);

    // Randomized traffic over a small hot address set to force collisions.
    for (int i = 0; i < 500; i++) begin
      logic [AW-1:0] wa, ba, a0, a1;
      wa = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      ba = ($urandom_range(0, 1) == 0) ? wa : AW'($urandom_range(0, 7));
      a0 = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, 7));
      a1 = ($urandom_range(0, 2) == 0) ? ba : AW'($urandom);
      step(($urandom_range(0, 15) != 0), $urandom_range(0, 1) == 1, wa, $urandom,
           a0, a1, $urandom_range(0, 2) == 0, ba, $urandom_range(0, 79) == 0,
           "rand", r0, r1, bz, rdy);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
